// File: rtl/scarv_cop_palu_seq.sv
// scarv_cop_palu_seq: in-order issue sequencer in front of the packed ALU.
// Buffers decoded PALU ops in a DEPTH-entry FIFO. It holds the head op on the
// PALU inputs until the PALU signals idone, then captures the result into a
// writeback register that is released through a valid/ready handshake. A
// pending-destination scoreboard lets decode stall on CPR hazards.
//
// Optional feature: define SCARV_COP_PALU_SEQ_WDOG_EN to add an EXEC watchdog
// (WDOG_CYCLES) that aborts a hung op and flags it through wb_err.
//
// Ports:
//   g_clk, g_reset          clock, synchronous active-high reset
//   dec_valid/dec_ready     decode offer / queue accept
//   dec_*                   operands and instruction fields, sampled on accept
//   palu_ivalid, gpr_rs1, palu_rs1..3, id_*   head op driven to the PALU
//   palu_idone, palu_cpr_rd_ben, palu_cpr_rd_wdata   PALU completion
//   wb_valid/wb_ready, wb_rd, wb_ben, wb_wdata       writeback handshake
//   wb_err                  watchdog abort flag (watchdog builds only)
//   pend_rd                 one bit per CPR with an in-flight write
//   busy                    queue non-empty or sequencer not idle
module scarv_cop_palu_seq #(
    parameter int unsigned DEPTH       = 2,   // 2 or 4 entries
    parameter int unsigned WDOG_CYCLES = 64
) (
    input  logic        g_clk,
    input  logic        g_reset,

    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic [31:0] dec_gpr_rs1,
    input  logic [31:0] dec_rs1,
    input  logic [31:0] dec_rs2,
    input  logic [31:0] dec_rs3,
    input  logic [31:0] dec_imm,
    input  logic [2:0]  dec_pw,
    input  logic [2:0]  dec_class,
    input  logic [3:0]  dec_subclass,
    input  logic [3:0]  dec_rd,

    output logic        palu_ivalid,
    output logic [31:0] gpr_rs1,
    output logic [31:0] palu_rs1,
    output logic [31:0] palu_rs2,
    output logic [31:0] palu_rs3,
    output logic [31:0] id_imm,
    output logic [2:0]  id_pw,
    output logic [2:0]  id_class,
    output logic [3:0]  id_subclass,

    input  logic        palu_idone,
    input  logic [3:0]  palu_cpr_rd_ben,
    input  logic [31:0] palu_cpr_rd_wdata,

    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [3:0]  wb_rd,
    output logic [3:0]  wb_ben,
    output logic [31:0] wb_wdata,

    output logic [15:0] pend_rd,
    output logic        busy
`ifdef SCARV_COP_PALU_SEQ_WDOG_EN
    ,
    output logic        wb_err
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef struct packed {
        logic [31:0] gpr_rs1;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] rs3;
        logic [31:0] imm;
        logic [2:0]  pw;
        logic [2:0]  cls;
        logic [3:0]  subclass;
        logic [3:0]  rd;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    entry_t             q_mem [DEPTH];
    entry_t             head_e;
    entry_t             push_e;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_nxt;
    logic               push;
    logic               pop;
    logic               wb_load;
    logic               wb_hs;
    logic [15:0]        set_mask;
    logic [15:0]        clr_mask;

    // Circular pointer advance, wrapping modulo DEPTH.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign dec_ready = !g_reset && (count < DEPTH_C);
    assign push      = dec_valid && dec_ready;
    assign wb_hs     = (state == S_WB) && wb_ready;
    assign head_e    = q_mem[head];

    assign push_e = '{gpr_rs1:  dec_gpr_rs1,
                      rs1:      dec_rs1,
                      rs2:      dec_rs2,
                      rs3:      dec_rs3,
                      imm:      dec_imm,
                      pw:       dec_pw,
                      cls:      dec_class,
                      subclass: dec_subclass,
                      rd:       dec_rd};

`ifdef SCARV_COP_PALU_SEQ_WDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt;
    logic              wdog_expire;
    logic              wb_abort;

    // Last permitted EXEC cycle without idone.
    assign wdog_expire = (state == S_EXEC) && (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

    // EXEC cycle counter; held at zero outside EXEC so every entry starts fresh.
    always_ff @(posedge g_clk) begin
        if (g_reset || (state != S_EXEC)) begin
            wdog_cnt <= '0;
        end else begin
            wdog_cnt <= wdog_cnt + WDOG_W'(1);
        end
    end
`else
    logic unused_wdog;
    assign unused_wdog = (WDOG_CYCLES == 0);
`endif

    // Next state and queue/writeback strobes.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        wb_load   = 1'b0;
`ifdef SCARV_COP_PALU_SEQ_WDOG_EN
        wb_abort  = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                // idone wins over a same-cycle watchdog expiry.
                if (palu_idone) begin
                    pop       = 1'b1;
                    wb_load   = 1'b1;
                    state_nxt = S_WB;
                end
`ifdef SCARV_COP_PALU_SEQ_WDOG_EN
                else if (wdog_expire) begin
                    pop       = 1'b1;
                    wb_abort  = 1'b1;
                    state_nxt = S_WB;
                end
`endif
            end
            S_WB: begin
                // No pop happens in WB, so occupancy after this cycle is count + push.
                if (wb_ready) begin
                    state_nxt = ((count != '0) || push) ? S_EXEC : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Occupancy update; push and pop together leave it unchanged.
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Scoreboard masks; a set applied after a clear makes the set win.
    assign set_mask = push  ? (16'(1) << dec_rd) : '0;
    assign clr_mask = wb_hs ? (16'(1) << wb_rd)  : '0;

    // Control state, pointers, scoreboard and writeback registers.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state    <= S_IDLE;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            pend_rd  <= '0;
            wb_rd    <= '0;
            wb_ben   <= '0;
            wb_wdata <= '0;
`ifdef SCARV_COP_PALU_SEQ_WDOG_EN
            wb_err   <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            pend_rd <= (pend_rd & ~clr_mask) | set_mask;
            if (push) begin
                tail <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            if (wb_load) begin
                wb_rd    <= head_e.rd;
                wb_ben   <= palu_cpr_rd_ben;
                wb_wdata <= palu_cpr_rd_wdata;
            end
`ifdef SCARV_COP_PALU_SEQ_WDOG_EN
            if (wb_load) begin
                wb_err <= 1'b0;
            end else if (wb_abort) begin
                wb_rd    <= head_e.rd;
                wb_ben   <= '0;
                wb_wdata <= '0;
                wb_err   <= 1'b1;
            end else if (wb_hs) begin
                wb_err <= 1'b0;
            end
`endif
        end
    end

    // Queue storage; contents are don't-care until written, so no reset.
    always_ff @(posedge g_clk) begin
        if (push) begin
            q_mem[tail] <= push_e;
        end
    end

    // PALU-facing outputs: head entry during EXEC, zero otherwise.
    always_comb begin
        palu_ivalid = 1'b0;
        gpr_rs1     = '0;
        palu_rs1    = '0;
        palu_rs2    = '0;
        palu_rs3    = '0;
        id_imm      = '0;
        id_pw       = '0;
        id_class    = '0;
        id_subclass = '0;
        if (state == S_EXEC) begin
            palu_ivalid = 1'b1;
            gpr_rs1     = head_e.gpr_rs1;
            palu_rs1    = head_e.rs1;
            palu_rs2    = head_e.rs2;
            palu_rs3    = head_e.rs3;
            id_imm      = head_e.imm;
            id_pw       = head_e.pw;
            id_class    = head_e.cls;
            id_subclass = head_e.subclass;
        end
    end

    assign wb_valid = (state == S_WB);
    assign busy     = (count != '0) || (state != S_IDLE);

endmodule
